rr_arbiter: RTL and testbench



---
 rtl/rr_arbiter.sv | 63 ++++++
 tb/tb_rr_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the priority pointer.
// Latency: grant is combinational from REQ, pointer and RSTn; the pointer moves on the next CLK edge.
// Backpressure: none; a grant is valid only for the cycle it is shown, and nothing is held across cycles.
module rr_arbiter #(
  parameter int NR = 5
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [NR-1:0] REQ,
  output logic [NR-1:0] GRT
);

  localparam int            PW   = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [PW-1:0] LAST = PW'(NR - 1);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;
  logic [PW-1:0] win_idx;
  logic          hi_found;
  logic          lo_found;
  logic          win_vld;

  // Lowest requesting index at/above ptr (hi) and below ptr (lo); hi wins, lo covers the wrap.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = 0; i < NR; i++) begin
      if (REQ[i] && !hi_found && (PW'(i) >= ptr)) begin
        hi_found = 1'b1;
        hi_idx   = PW'(i);
      end
      if (REQ[i] && !lo_found && (PW'(i) < ptr)) begin
        lo_found = 1'b1;
        lo_idx   = PW'(i);
      end
    end
  end

  // Pick the winner, build the one-hot grant and force it low while reset is held.
  always_comb begin
    win_vld = RSTn && (hi_found || lo_found);
    win_idx = hi_found ? hi_idx : lo_idx;
    ptr_nxt = (win_idx == LAST) ? '0 : win_idx + PW'(1);
    GRT     = '0;
    for (int i = 0; i < NR; i++) begin
      GRT[i] = win_vld && (win_idx == PW'(i));
    end
  end

  // Winner drops to lowest priority next cycle; pointer holds when nothing is granted.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      ptr <= '0;
    end else if (win_vld) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed vector table, intra-cycle corner cases,
// and a randomized comparison against a search-order reference for NR=5 and NR=4.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] req5;
  logic [4:0] grt5;
  logic [3:0] req4;
  logic [3:0] grt4;

  always #5 clk = ~clk;

  rr_arbiter #(.NR(5)) dut5 (.CLK(clk), .RSTn(rstn), .REQ(req5), .GRT(grt5));
  rr_arbiter #(.NR(4)) dut4 (.CLK(clk), .RSTn(rstn), .REQ(req4), .GRT(grt4));

  typedef struct {
    logic       rstn;
    logic [4:0] req;
    logic [4:0] grt;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] sb5[$];
  logic [3:0] sb4[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic r, input logic [4:0] q, input logic [4:0] g);
    vec_t v;
    v.rstn = r;
    v.req  = q;
    v.grt  = g;
    vecs.push_back(v);
  endtask

  // Reference: scan from p upward with modulo-n wrap, first requester wins.
  function automatic logic [4:0] ref_grant(input int n, input int p, input logic [4:0] r);
    logic [4:0] one;
    one = 5'd1;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (p + k) % n;
      if (r[idx]) return one << idx;
    end
    return 5'd0;
  endfunction

  function automatic int onehot_idx(input logic [4:0] g);
    for (int i = 0; i < 5; i++) begin
      if (g[i]) return i;
    end
    return 0;
  endfunction

  initial begin
    int         p5;
    int         p4;
    logic       prev_rstn;
    logic [4:0] prev_e5;
    logic [4:0] prev_e4;
    logic [4:0] e5;
    logic [4:0] e4;
    logic [4:0] r5;

    rstn = 1'b0;
    req5 = '0;
    req4 = '0;

    // Reset held with bit 4 requesting, then release: bit 4 granted every cycle, pointer wraps 4->0.
    add_vec(1'b0, 5'b10000, 5'b00000);
    add_vec(1'b0, 5'b10000, 5'b00000);
    add_vec(1'b1, 5'b10000, 5'b10000);
    add_vec(1'b1, 5'b10000, 5'b10000);
    add_vec(1'b1, 5'b10000, 5'b10000);
    // Directed sequence from pointer 0.
    add_vec(1'b1, 5'b10001, 5'b00001);
    add_vec(1'b1, 5'b00001, 5'b00001);
    add_vec(1'b1, 5'b00010, 5'b00010);
    add_vec(1'b1, 5'b11100, 5'b00100);
    add_vec(1'b1, 5'b01000, 5'b01000);
    add_vec(1'b1, 5'b10000, 5'b10000);
    add_vec(1'b1, 5'b11100, 5'b00100);
    // Reset, then all requesting for 10 cycles: strict rotation.
    add_vec(1'b0, 5'b11111, 5'b00000);
    for (int i = 0; i < 10; i++) add_vec(1'b1, 5'b11111, 5'b00001 << (i % 5));
    // Grant bit 2, idle 3 cycles, pointer must still be 3.
    add_vec(1'b1, 5'b00100, 5'b00100);
    add_vec(1'b1, 5'b00000, 5'b00000);
    add_vec(1'b1, 5'b00000, 5'b00000);
    add_vec(1'b1, 5'b00000, 5'b00000);
    add_vec(1'b1, 5'b01001, 5'b01000);
    // Mid-operation reset after pointer reaches 3.
    add_vec(1'b1, 5'b00100, 5'b00100);
    add_vec(1'b0, 5'b11111, 5'b00000);
    add_vec(1'b1, 5'b11111, 5'b00001);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rstn = vecs[i].rstn;
      req5 = vecs[i].req;
      sb5.push_back(vecs[i].grt);
      @(negedge clk);
      check($sformatf("vec%0d", i), grt5, sb5.pop_front());
    end

    // Pointer is 1 here. REQ changing inside one cycle moves GRT immediately,
    // and the pointer follows the grant present at the edge.
    @(posedge clk);
    #1;
    rstn = 1'b1;
    req5 = 5'b00010;
    #2 check("comb_first", grt5, 5'b00010);
    req5 = 5'b10000;
    #1 check("comb_second", grt5, 5'b10000);
    @(posedge clk);
    #1;
    req5 = 5'b11111;
    #1 check("comb_ptr_wrap", grt5, 5'b00001);
    // Reset asserted mid-cycle clears GRT at once; the edge then returns the pointer to 0.
    #1 rstn = 1'b0;
    #1 check("rst_immediate", grt5, 5'b00000);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    req5 = 5'b10001;
    #1 check("rst_ptr_zero", grt5, 5'b00001);

    // Randomized phase against the reference model, both widths.
    p5        = 0;
    p4        = 0;
    prev_rstn = 1'b0;
    prev_e5   = '0;
    prev_e4   = '0;
    for (int it = 0; it < 400; it++) begin
      @(posedge clk);
      if (it == 0 || !prev_rstn) begin
        p5 = 0;
        p4 = 0;
      end else begin
        if (prev_e5 != 0) p5 = (onehot_idx(prev_e5) + 1) % 5;
        if (prev_e4 != 0) p4 = (onehot_idx(prev_e4) + 1) % 4;
      end
      #1;
      rstn = (it == 0) ? 1'b0 : ($urandom_range(0, 19) != 0);
      r5   = 5'($urandom);
      if (it % 2 == 1) r5 = r5 & 5'($urandom);
      req5 = r5;
      req4 = 4'($urandom);
      e5   = rstn ? ref_grant(5, p5, req5) : 5'd0;
      e4   = rstn ? ref_grant(4, p4, {1'b0, req4}) : 5'd0;
      sb5.push_back(e5);
      sb4.push_back(e4[3:0]);
      prev_rstn = rstn;
      prev_e5   = e5;
      prev_e4   = e4;
      @(negedge clk);
      check($sformatf("rand5_%0d", it), grt5, sb5.pop_front());
      check($sformatf("rand4_%0d", it), {1'b0, grt4}, {1'b0, sb4.pop_front()});
      check($sformatf("subset5_%0d", it), grt5 & ~req5, 5'd0);
      check($sformatf("onehot4_%0d", it), 5'($countones(grt4) <= 1), 5'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
